// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one fixed-latency memory.
// Data wins by default; a saturating streak counter bounds how long a pending fetch can starve.
module mem_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_func3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] LAT        = 3'(MEM_LAT);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        discard_q, discard_d;
    logic        gnt_data_q, gnt_data_d;   // owner of the current transaction: 1 = data port
    logic        store_q, store_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_func3_q, mem_func3_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_data, grant_fetch;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        gnt_data_d  = gnt_data_q;
        store_d     = store_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_func3_d = mem_func3_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !(if_req && streak_q == STREAK_MAX)) begin
                    grant_data = 1'b1;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                end
            end
            ACCESS: begin
                discard_d = discard_q | (if_flush & ~gnt_data_q);
                if (store_q) begin
                    d_ack_d = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    if (gnt_data_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_rdata;
                    end else if (!discard_d) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                // The requester just acked still holds its req this cycle, so only the other side may be granted.
                discard_d = 1'b0;
                if (gnt_data_q && if_req) begin
                    grant_fetch = 1'b1;
                end else if (!gnt_data_q && d_req) begin
                    grant_data = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_data) begin
            state_d     = ACCESS;
            gnt_data_d  = 1'b1;
            store_d     = d_we;
            cnt_d       = LAT;
            mem_en_d    = 1'b1;
            mem_we_d    = d_we;
            mem_func3_d = d_func3;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            streak_d    = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
        end else if (grant_fetch) begin
            state_d     = ACCESS;
            gnt_data_d  = 1'b0;
            store_d     = 1'b0;
            cnt_d       = LAT;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_func3_d = 3'b010;
            mem_addr_d  = if_addr;
            streak_d    = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            cnt_q       <= 3'd0;
            discard_q   <= 1'b0;
            gnt_data_q  <= 1'b0;
            store_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_func3_q <= 3'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            gnt_data_q  <= gnt_data_d;
            store_q     <= store_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_func3_q <= mem_func3_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_func3 = mem_func3_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios plus randomized traffic, with
// expected responses queued at issue time and checked by an independent monitor.
module tb_mem_arbiter;
    localparam int L  = 2;
    localparam int MS = 2;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        if_req    = 1'b0;
    logic [31:0] if_addr   = 32'd0;
    logic        if_flush  = 1'b0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req     = 1'b0;
    logic        d_we      = 1'b0;
    logic [2:0]  d_func3   = 3'd0;
    logic [31:0] d_addr    = 32'd0;
    logic [31:0] d_wdata   = 32'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    mem_arbiter #(.MEM_LAT(L), .MAX_D_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Power-on memory contents; fetch region 0x1000-0x1FFF (plus 0x100), data region elsewhere.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
    endfunction

    function automatic bit is_fetch_addr(input logic [31:0] a);
        return (a == 32'h100) || (a[31:12] == 20'h1);
    endfunction

    // Memory environment: word memory answering MEM_LAT cycles after mem_en, noise otherwise.
    logic [31:0] env_mem [logic [31:0]];
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'd0;

    always begin
        @(negedge clk);
        if (rst && mem_en) begin
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            else begin
                pend_cnt  = L;
                pend_addr = mem_addr;
            end
        end
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0)
                mem_rdata = env_mem.exists(pend_addr) ? env_mem[pend_addr] : init_word(pend_addr);
        end
    end

    // Reference model of the data memory as seen by the data requester.
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct packed {
        logic        store;
        logic [31:0] rdata;
    } dexp_t;

    logic [31:0] ifq [$];
    dexp_t       dq  [$];

    int gnt_cyc   [$];
    bit gnt_fetch [$];
    int ifack_cyc [$];
    int dack_cyc  [$];

    task automatic clear_logs();
        gnt_cyc.delete();
        gnt_fetch.delete();
        ifack_cyc.delete();
        dack_cyc.delete();
    endtask

    // Monitor: protocol checks on every grant, scoreboard pops on every ack.
    int   f_gcyc      = 0;
    int   d_gcyc      = 0;
    logic d_gstore    = 1'b0;
    int   dstreak     = 0;
    logic if_req_prev = 1'b0;

    always @(negedge clk) begin
        logic [31:0] ew;
        dexp_t       de;
        if (!rst) begin
            dstreak     = 0;
            if_req_prev = 1'b0;
        end else begin
            if (mem_en) begin
                gnt_cyc.push_back(cyc);
                if (is_fetch_addr(mem_addr)) begin
                    gnt_fetch.push_back(1'b1);
                    check("fetch_addr", mem_addr, if_addr);
                    check("fetch_func3", 32'(mem_func3), 32'h2);
                    check("fetch_we", 32'(mem_we), 32'h0);
                    f_gcyc  = cyc;
                    dstreak = 0;
                end else begin
                    gnt_fetch.push_back(1'b0);
                    check("data_addr", mem_addr, d_addr);
                    check("data_func3", 32'(mem_func3), 32'(d_func3));
                    check("data_we", 32'(mem_we), 32'(d_we));
                    if (d_we) check("data_wdata", mem_wdata, d_wdata);
                    check("data_priority", 32'(if_req_prev && dstreak == MS), 32'h0);
                    if (dstreak < MS) dstreak++;
                    d_gcyc   = cyc;
                    d_gstore = mem_we;
                end
            end
            if (if_ack) begin
                ifack_cyc.push_back(cyc);
                check("if_ack_latency", cyc, f_gcyc + L + 1);
                if (ifq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL if_ack_unexpected: actual if_ack=1 required 0 (cycle %0d)", cyc);
                end else begin
                    ew = ifq.pop_front();
                    check("if_rdata", if_rdata, ew);
                    $display("cyc %0d fetch ack addr %h rdata %h", cyc, if_addr, if_rdata);
                end
            end
            if (d_ack) begin
                dack_cyc.push_back(cyc);
                check("d_ack_latency", cyc, d_gcyc + (d_gstore ? 1 : L + 1));
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d_ack_unexpected: actual d_ack=1 required 0 (cycle %0d)", cyc);
                end else begin
                    de = dq.pop_front();
                    check("d_kind", 32'(d_gstore), 32'(de.store));
                    if (!de.store) check("d_rdata", d_rdata, de.rdata);
                    $display("cyc %0d data ack %s addr %h data %h", cyc, de.store ? "store" : "load",
                             d_addr, de.store ? d_wdata : d_rdata);
                end
            end
            if_req_prev = if_req;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input bit is_fetch, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_fetch ? if_ack : d_ack) && n < 200);
        if (!(is_fetch ? if_ack : d_ack)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual no ack required ack within 200 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
        ifq.push_back(exp);
        if_req  = 1'b1;
        if_addr = a;
        wait_ack(1'b1, "fetch");
        if_req  = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        dexp_t e;
        e.store = we;
        e.rdata = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        if (we) ref_mem[a] = wd;
        dq.push_back(e);
        d_req   = 1'b1;
        d_we    = we;
        d_func3 = f3;
        d_addr  = a;
        d_wdata = wd;
        wait_ack(1'b0, "data");
        d_req   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        env_mem[32'h100] = 32'h0050_0093;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_if_ack", 32'(if_ack), 32'h0);
        check("rst_d_ack", 32'(d_ack), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        rst = 1'b1;
        idle(2);

        // Single fetch
        clear_logs();
        c0 = cyc;
        do_fetch(32'h100, 32'h0050_0093);
        idle(2);
        check("t1_grants", gnt_cyc.size(), 1);
        if (gnt_cyc.size() >= 1) check("t1_en_cycle", gnt_cyc[0], c0 + 1);
        check("t1_acks", ifack_cyc.size(), 1);
        if (ifack_cyc.size() >= 1) check("t1_ack_cycle", ifack_cyc[0], c0 + 4);
        check("t1_if_rdata_hold", if_rdata, 32'h0050_0093);

        // Simultaneous fetch and load: data first
        clear_logs();
        c0 = cyc;
        fork
            do_fetch(32'h1000, init_word(32'h1000));
            do_data(1'b0, 3'b010, 32'h200, 32'h0);
        join
        idle(2);
        check("t2_grants", gnt_cyc.size(), 2);
        if (gnt_cyc.size() >= 2) begin
            check("t2_data_en", gnt_cyc[0], c0 + 1);
            check("t2_data_first", 32'(gnt_fetch[0]), 32'h0);
            check("t2_fetch_en", gnt_cyc[1], c0 + 5);
        end
        if (dack_cyc.size() >= 1) check("t2_d_ack_cycle", dack_cyc[0], c0 + 4);
        if (ifack_cyc.size() >= 1) check("t2_if_ack_cycle", ifack_cyc[0], c0 + 8);

        // Store, then read it back
        clear_logs();
        c0 = cyc;
        do_data(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        if (gnt_cyc.size() >= 1) check("t3_en_cycle", gnt_cyc[0], c0 + 1);
        check("t3_acks", dack_cyc.size(), 1);
        if (dack_cyc.size() >= 1) check("t3_ack_cycle", dack_cyc[0], c0 + 2);
        do_data(1'b0, 3'b010, 32'h40, 32'h0);
        check("t3_load_back", d_rdata, 32'hDEAD_BEEF);

        // Starvation: fetch arrives after the first data grant
        do_fetch(32'h1004, init_word(32'h1004));
        idle(1);
        clear_logs();
        c0 = cyc;
        fork
            begin
                do_data(1'b0, 3'b010, 32'h2000, 32'h0);
                do_data(1'b0, 3'b010, 32'h2004, 32'h0);
                do_data(1'b0, 3'b010, 32'h2008, 32'h0);
            end
            begin
                idle(5);
                do_fetch(32'h1008, init_word(32'h1008));
            end
        join
        idle(2);
        check("t4_grants", gnt_cyc.size(), 4);
        if (gnt_cyc.size() >= 4) begin
            check("t4_g0", gnt_cyc[0], c0 + 1);
            check("t4_g1", gnt_cyc[1], c0 + 6);
            check("t4_g1_data", 32'(gnt_fetch[1]), 32'h0);
            check("t4_g2", gnt_cyc[2], c0 + 10);
            check("t4_g2_fetch", 32'(gnt_fetch[2]), 32'h1);
            check("t4_g3", gnt_cyc[3], c0 + 14);
        end

        // Streak at its limit: contending fetch wins in IDLE
        do_data(1'b0, 3'b010, 32'h200C, 32'h0);
        idle(1);
        clear_logs();
        c0 = cyc;
        fork
            do_fetch(32'h1010, init_word(32'h1010));
            do_data(1'b0, 3'b010, 32'h2010, 32'h0);
        join
        idle(1);
        if (gnt_cyc.size() >= 2) begin
            check("t4b_fetch_first", 32'(gnt_fetch[0]), 32'h1);
            check("t4b_g0", gnt_cyc[0], c0 + 1);
            check("t4b_g1", gnt_cyc[1], c0 + 5);
        end else check("t4b_grants", gnt_cyc.size(), 2);

        // Flush during ACCESS: no ack, FSM idle in cycle 5
        clear_logs();
        c0 = cyc;
        if_req  = 1'b1;
        if_addr = 32'h1014;
        idle(2);
        if_flush = 1'b1;
        idle(1);
        if_flush = 1'b0;
        if_req   = 1'b0;
        idle(2);
        do_data(1'b0, 3'b010, 32'h2014, 32'h0);
        idle(1);
        check("t5_if_acks", ifack_cyc.size(), 0);
        check("t5_grants", gnt_cyc.size(), 2);
        if (gnt_cyc.size() >= 2) check("t5_idle_grant", gnt_cyc[1], c0 + 6);
        if (dack_cyc.size() >= 1) check("t5_d_ack_cycle", dack_cyc[0], c0 + 9);

        // Flush in IDLE and in RESP is ignored
        clear_logs();
        c0 = cyc;
        ifq.push_back(init_word(32'h1018));
        if_req   = 1'b1;
        if_addr  = 32'h1018;
        if_flush = 1'b1;
        idle(1);
        if_flush = 1'b0;
        idle(3);
        if_flush = 1'b1;
        idle(1);
        if_flush = 1'b0;
        if_req   = 1'b0;
        do_fetch(32'h101C, init_word(32'h101C));
        check("t5b_if_acks", ifack_cyc.size(), 2);
        if (ifack_cyc.size() >= 1) check("t5b_ack_cycle", ifack_cyc[0], c0 + 4);

        // Reset in the middle of ACCESS
        idle(1);
        clear_logs();
        c0 = cyc;
        if_req  = 1'b1;
        if_addr = 32'h1020;
        idle(2);
        rst = 1'b0;
        #1;
        check("t6_mem_en", 32'(mem_en), 32'h0);
        check("t6_mem_we", 32'(mem_we), 32'h0);
        check("t6_if_ack", 32'(if_ack), 32'h0);
        check("t6_d_ack", 32'(d_ack), 32'h0);
        check("t6_mem_addr", mem_addr, 32'h0);
        check("t6_mem_func3", 32'(mem_func3), 32'h0);
        check("t6_mem_wdata", mem_wdata, 32'h0);
        check("t6_if_rdata", if_rdata, 32'h0);
        check("t6_d_rdata", d_rdata, 32'h0);
        if_req = 1'b0;
        idle(2);
        clear_logs();
        rst = 1'b1;
        c0  = cyc;
        do_data(1'b0, 3'b010, 32'h2018, 32'h0);
        idle(3);
        if (gnt_cyc.size() >= 1) check("t6_first_grant", gnt_cyc[0], c0 + 1);
        else check("t6_grants", gnt_cyc.size(), 1);
        check("t6_no_if_ack", ifack_cyc.size(), 0);

        // Randomized traffic on both ports
        fork
            begin : fetch_drv
                logic [31:0] fa;
                for (int i = 0; i < 40; i++) begin
                    idle($urandom_range(0, 3));
                    fa = 32'h1000 + 32'(4 * $urandom_range(0, 255));
                    do_fetch(fa, init_word(fa));
                end
            end
            begin : data_drv
                logic [31:0] da;
                logic        dw;
                for (int i = 0; i < 60; i++) begin
                    idle($urandom_range(0, 2));
                    da = 32'h2000 + 32'(4 * $urandom_range(0, 15));
                    dw = 1'($urandom_range(0, 1));
                    do_data(dw, 3'($urandom_range(0, 7)), da, $urandom);
                end
            end
        join
        idle(5);
        check("ifq_drained", ifq.size(), 0);
        check("dq_drained", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles, from mem_en to valid mem_rdata; legal range 1..7.
REQ-002 Parameter MAX_D_STREAK, default 4: maximum consecutive data grants while a fetch waits; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch request, level; held with if_addr stable until if_ack.
REQ-006 if_addr  in  32  fetch word address.
REQ-007 if_flush  in  1  discard the in-flight fetch (taken branch or jump).
REQ-008 if_ack  out  1  one-cycle pulse; if_rdata is valid in this cycle.
REQ-009 if_rdata  out  32  fetched instruction.
REQ-010 d_req  in  1  data request, level; held with d_we, d_func3, d_addr and d_wdata stable until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_func3  in  3  access size and sign, passed to the memory.
REQ-013 d_addr, d_wdata  in  32 each  data address and store data.
REQ-014 d_ack  out  1  one-cycle pulse; d_rdata is valid in this cycle for loads.
REQ-015 d_rdata  out  32  load data.
REQ-016 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-017 mem_func3  out  3  access size; 3'b010 for fetches.
REQ-018 mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-019 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and RESP; all outputs are registered.
REQ-021 IDLE: when any request is high, the arbiter grants one requester, registers its controls onto mem_*, drives mem_en=1 for exactly one cycle, and enters ACCESS.
REQ-022 Priority: data wins, unless if_req is high and streak == MAX_D_STREAK; in that case fetch wins.
REQ-023 streak SHALL increment on each data grant, saturating at MAX_D_STREAK, and clear on each fetch grant.
REQ-024 ACCESS, load or fetch: a 3-bit counter is loaded with MEM_LAT and decremented each cycle; when it reaches 0, mem_rdata is captured into the granted requester's rdata register and the FSM enters RESP.
REQ-025 ACCESS, store: mem_we=1 in the mem_en cycle only, and the FSM enters RESP on the next edge (store latency is independent of MEM_LAT).
REQ-026 RESP: the granted requester's ack is 1 for exactly this cycle, and its req is masked in this cycle.
REQ-027 RESP: if the other requester's req is high, it is granted directly, with mem_en in the next cycle; otherwise the FSM returns to IDLE.
REQ-028 Request-to-ack latency: MEM_LAT+2 cycles for loads and fetches; 2 cycles for stores.
REQ-029 if_flush high in any cycle of a fetch's ACCESS state sets a discard flag; that RESP then suppresses if_ack, and the flag clears.
REQ-030 if_flush in the RESP cycle or in IDLE has no effect.
REQ-031 mem_addr, mem_func3 and mem_wdata SHALL hold their values outside mem_en cycles.
REQ-032 mem_func3 = 3'b010 and mem_we = 0 for every fetch.

Reset
REQ-033 When rst = 0, the block SHALL immediately force: state = IDLE; streak, counter and discard flag = 0; all outputs = 0.
REQ-034 Reset mid-ACCESS SHALL abort the transaction with no ack; the requester re-issues after reset.
REQ-035 After rst deasserts, the first grant can occur on the first rising edge.

Verification (MEM_LAT=2, MAX_D_STREAK=2; cycle 0 = the request cycle)
REQ-036 Single fetch: if_req, if_addr=0x100, mem_rdata=0x00500093 -> mem_en in cycle 1 with mem_addr=0x100; if_ack in cycle 4 with if_rdata=0x00500093.
REQ-037 Simultaneous requests: if_req and a d_req load to 0x200 -> data mem_en in cycle 1; d_ack in cycle 4; fetch mem_en in cycle 5; if_ack in cycle 8.
REQ-038 Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_func3=010 -> mem_en=mem_we=1 in cycle 1; d_ack in cycle 2.
REQ-039 Starvation: d_req held continuously with if_req pending -> two data grants, then a fetch grant; data resumes after the fetch's RESP.
REQ-040 Flush: if_flush in cycle 2 of a fetch -> if_ack never asserted; FSM back in IDLE in cycle 5.
REQ-041 Reset mid-ACCESS: rst=0 in cycle 2 -> mem_en, if_ack and d_ack = 0 at once; state IDLE; no ack after release.
